// File: rtl/coin_detector.sv
// rtl/coin_detector.sv - coin sensor conditioner: sync, debounce, edge detect, accept/lockout FSM
// Define COIN_DET_SYNC_EN to add a 2-flop synchronizer on each raw sensor line.
module coin_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin50_raw,
  input  logic       coin100_raw,
  output logic [1:0] x,
  output logic       reject,
  output logic       busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EMIT, LOCKOUT} state_t;

  // Bit 0 is the 50c channel, bit 1 the 1-euro channel, so an event vector is its own coin code.
  logic [1:0] raw;
  logic [1:0] s;
  assign raw = {coin100_raw, coin50_raw};

`ifdef COIN_DET_SYNC_EN
  logic [1:0] meta_q;
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end
  assign s = sync_q;
`else
  assign s = raw;
`endif

  logic [1:0]         deb_q, deb_d;
  logic [1:0]         deb_dly_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         ev;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (s[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign ev = deb_q & ~deb_dly_q;

  state_t        state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [1:0]    x_q, x_d;
  logic          reject_q, reject_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    x_d      = 2'b00;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev == 2'b11) begin
          reject_d = 1'b1;
          lock_d   = LOCK_LOAD;
          state_d  = LOCKOUT;
        end else if (ev != 2'b00) begin
          x_d     = ev;
          state_d = EMIT;
        end
      end
      EMIT: begin
        reject_d = |ev;
        lock_d   = LOCK_LOAD;
        state_d  = LOCKOUT;
      end
      LOCKOUT: begin
        reject_d = |ev;
        if (lock_q == '0) begin
          state_d = IDLE;
        end else begin
          lock_d = lock_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Held one extra cycle on the way back to IDLE so the coin gate sees the exit cycle.
    busy_d = (state_d != IDLE) || (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lock_q   <= '0;
      x_q      <= 2'b00;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      x_q      <= x_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
    end
  end

  assign x      = x_q;
  assign reject = reject_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_coin_detector.sv
// tb/tb_coin_detector.sv - directed bench for coin_detector with a cycle-level reference model
module tb_coin_detector;
  localparam int D = 4;
  localparam int L = 8;
`ifdef COIN_DET_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int LAT = D + SL;

  typedef bit bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       coin50_raw;
  logic       coin100_raw;
  logic [1:0] x;
  logic       reject;
  logic       busy;

  coin_detector #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin50_raw (coin50_raw),
    .coin100_raw(coin100_raw),
    .x          (x),
    .reject     (reject),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: sensor delay lines, sliding debounce windows, and the edge at which the FSM is next free.
  bq_t        dly50, dly100, win50, win100;
  logic [1:0] m_deb = 2'b00;
  logic [1:0] m_rise = 2'b00;
  int         free_at = 0;
  logic [1:0] exp_x = 2'b00;
  logic       exp_rej = 1'b0;
  logic       exp_busy = 1'b0;

  int n_x, n_rej, n_busy, x_edge, rej_edge, x_code;

  function automatic bit all_differ(input bq_t q, input bit lvl);
    foreach (q[k]) if (q[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
    end
  endtask

  task automatic model_edge();
    bit s50, s100;
    exp_x   = 2'b00;
    exp_rej = 1'b0;
    if (rst) begin
      free_at  = cyc + 1;
      exp_busy = 1'b0;
      dly50.delete();
      dly100.delete();
      for (int k = 0; k < SL; k++) begin
        dly50.push_back(1'b0);
        dly100.push_back(1'b0);
      end
      win50.delete();
      win100.delete();
      m_deb  = 2'b00;
      m_rise = 2'b00;
      return;
    end
    if (cyc >= free_at) begin
      if (m_rise == 2'b11) begin
        exp_rej = 1'b1;
        free_at = cyc + L + 1;
      end else if (m_rise != 2'b00) begin
        exp_x   = m_rise;
        free_at = cyc + L + 2;
      end
    end else if (m_rise != 2'b00) begin
      exp_rej = 1'b1;
    end
    exp_busy = (cyc < free_at);

    dly50.push_back(coin50_raw);
    dly100.push_back(coin100_raw);
    s50  = dly50.pop_front();
    s100 = dly100.pop_front();
    m_rise = 2'b00;
    win50.push_back(s50);
    win100.push_back(s100);
    if (win50.size() > D) void'(win50.pop_front());
    if (win100.size() > D) void'(win100.pop_front());
    if (win50.size() == D && all_differ(win50, m_deb[0])) begin
      m_deb[0]  = s50;
      m_rise[0] = s50;
    end
    if (win100.size() == D && all_differ(win100, m_deb[1])) begin
      m_deb[1]  = s100;
      m_rise[1] = s100;
    end
  endtask

  task automatic compare();
    chk("x", int'(x), int'(exp_x));
    chk("reject", int'(reject), int'(exp_rej));
    chk("busy", int'(busy), int'(exp_busy));
    if (x != 2'b00) begin
      n_x++;
      x_edge = cyc;
      x_code = int'(x);
    end
    if (reject) begin
      n_rej++;
      rej_edge = cyc;
    end
    if (busy) n_busy++;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr();
    n_x = 0; n_rej = 0; n_busy = 0;
    x_edge = -1; rej_edge = -1; x_code = 0;
  endtask

  initial begin
    int e;
    bit pat[5];
    rst = 1'b1;
    coin50_raw = 1'b0;
    coin100_raw = 1'b0;
    run(3);
    chk("rst_x", int'(x), 0);
    chk("rst_reject", int'(reject), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    run(10);

    // Clean 50c coin
    clr();
    coin50_raw = 1'b1;
    e = cyc + 1;
    run(20);
    coin50_raw = 1'b0;
    run(25);
    chk("s1_pulses", n_x, 1);
    chk("s1_code", x_code, 1);
    chk("s1_latency", x_edge - e, LAT);
    chk("s1_busy_len", n_busy, 10);
    chk("s1_rejects", n_rej, 0);

    // Bouncing 1-euro coin
    clr();
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      coin100_raw = pat[k];
      run(1);
    end
    e = cyc;
    run(20);
    coin100_raw = 1'b0;
    run(25);
    chk("s2_pulses", n_x, 1);
    chk("s2_code", x_code, 2);
    chk("s2_latency", x_edge - e, LAT);
    chk("s2_rejects", n_rej, 0);

    // Simultaneous insertion
    clr();
    coin50_raw = 1'b1;
    coin100_raw = 1'b1;
    e = cyc + 1;
    run(20);
    coin50_raw = 1'b0;
    coin100_raw = 1'b0;
    run(25);
    chk("s3_pulses", n_x, 0);
    chk("s3_rejects", n_rej, 1);
    chk("s3_rej_latency", rej_edge - e, LAT);
    chk("s3_busy_len", n_busy, 9);

    // Second coin during lockout
    clr();
    coin50_raw = 1'b1;
    e = cyc + 1;
    run(3);
    coin100_raw = 1'b1;
    run(20);
    coin50_raw = 1'b0;
    coin100_raw = 1'b0;
    run(25);
    chk("s4_pulses", n_x, 1);
    chk("s4_code", x_code, 1);
    chk("s4_rejects", n_rej, 1);
    chk("s4_rej_offset", rej_edge - e, LAT + 3);
    chk("s4_busy_len", n_busy, 10);

    // Reset on the edge that would register x
    clr();
    coin50_raw = 1'b1;
    run(LAT);
    rst = 1'b1;
    run(1);
    chk("s5_rst_x", int'(x), 0);
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_pre_pulses", n_x, 0);
    rst = 1'b0;
    e = cyc + 1;
    run(20);
    coin50_raw = 1'b0;
    run(25);
    chk("s5_pulses", n_x, 1);
    chk("s5_latency", x_edge - e, LAT);
    chk("s5_busy_len", n_busy, 10);

    // Short glitch
    clr();
    coin50_raw = 1'b1;
    run(3);
    coin50_raw = 1'b0;
    run(25);
    chk("s6_pulses", n_x, 0);
    chk("s6_rejects", n_rej, 0);
    chk("s6_busy_len", n_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coin_detector.md
# coin_detector

Coin-slot front end for the beverage vending controller. Two raw, asynchronous, bouncing coin-sensor lines (50 cent, 1 euro) are conditioned into clean single-cycle coin codes on `x[1:0]`, which drive the vending FSM's coin input directly. Simultaneous or too-closely-spaced insertions are flagged on `reject` so the coin-return gate opens, and are never forwarded.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized input must differ from its debounced level before that level flips (>= 1).
- `LOCKOUT_CYCLES`, default 8: dead time after each accepted or rejected coin (>= 1).
- `clk`  input  1  single clock, all logic rising-edge.
- `rst`  input  1  reset; synchronous, active-high.
- `coin50_raw`  input  1  50-cent sensor, asynchronous, bouncing, high while a coin passes.
- `coin100_raw`  input  1  1-euro sensor, same properties.
- `x`  output  2  coin code, registered: 2'b00 none, 2'b01 50 cent, 2'b10 1 euro; never 2'b11.
- `reject`  output  1  registered one-cycle pulse; a coin event was dropped.
- `busy`  output  1  registered; high whenever the FSM is not in IDLE.

## Operation
- Per channel: optional 2-flop synchronizer, then debouncer, then rising-edge detector.
- Debouncer input `s` is the synchronized line, or the raw line when the synchronizer is compiled out.
- Debouncer state: level `deb` and counter `cnt`. The counter is $clog2(DEBOUNCE_CYCLES+1) bits wide and never wraps.
- Debouncer update, each edge:
  - `s == deb`: `cnt <= 0`.
  - else if `cnt == DEBOUNCE_CYCLES-1`: `deb <= s`, `cnt <= 0`.
  - else: `cnt <= cnt+1`.
- Event: `ev = deb & ~deb_d`, where `deb_d` is `deb` delayed one cycle. Falling edges generate nothing.
- FSM states: IDLE, EMIT, LOCKOUT.
  - IDLE, exactly one event: `x <=` its code, go to EMIT.
  - IDLE, both events in the same cycle: `reject <= 1`, `x` stays 00, go to LOCKOUT.
  - IDLE, no event: stay.
  - EMIT: `x <= 00`, load the lockout counter with LOCKOUT_CYCLES-1, go to LOCKOUT.
  - LOCKOUT: decrement the counter; at 0 go to IDLE. The lockout counter is $clog2(LOCKOUT_CYCLES) bits wide, minimum 1.
  - Reject path into LOCKOUT loads the same counter with LOCKOUT_CYCLES-1.
- Any event arriving in EMIT or LOCKOUT is dropped and pulses `reject` for one cycle. The FSM and the lockout counter are unaffected.
- `reject` and a nonzero `x` are never high in the same cycle.
- Reset clears synchronizer flops, `deb`, `deb_d`, `cnt`, lockout counter and FSM (IDLE).
- Outputs after reset: `x = 00`, `reject = 0`, `busy = 0`.
- Reset mid-operation aborts any pending pulse. A sensor still high at reset release is treated as a new insertion once debounced.

## Timing
- Latency is counted from E, the first edge at which a raw line is sampled high and then held stable.
  - With synchronizer: `x` valid in the cycle after edge E+DEBOUNCE_CYCLES+2.
  - Without synchronizer: `x` valid in the cycle after edge E+DEBOUNCE_CYCLES.
- `x` is nonzero for exactly one cycle per accepted coin.
- `reject` for a simultaneous pair has the same latency as `x`.
- Minimum spacing between two accepted coins: 1 (EMIT) + LOCKOUT_CYCLES + 1 cycles, counted between `x` pulses.
- `busy` rises in the same cycle as `x`/`reject` and falls the cycle after the lockout counter reaches 0.
- A bounce shorter than DEBOUNCE_CYCLES cycles never changes `deb`, and never produces `x` or `reject`.

## Configuration
- `COIN_DET_SYNC_EN` defined: 2-flop synchronizer on each raw input; latency as stated above.
- `COIN_DET_SYNC_EN` undefined: synchronizers removed. Raw inputs must already be synchronous to `clk`, and latency shrinks by 2 cycles.
- The debounce, FSM and all other behaviour are identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, `COIN_DET_SYNC_EN` defined.
- Clean 50c: `coin50_raw` high from edge 10 for 20 cycles -> `x = 01` for one cycle after edge 16; `busy` high for 10 cycles (1 EMIT + 8 LOCKOUT + exit cycle); `reject` stays 0.
- Bounce: `coin100_raw` toggles 1,0,1,0,1 per cycle, then holds high -> no output during toggling; exactly one `x = 10` pulse, 6 edges after the last rising edge of the raw line.
- Simultaneous: both raw lines rise at edge 10 -> `reject` pulse after edge 16, `x` stays 00, `busy` high through lockout.
- Lockout drop: 50c accepted, then a 1-euro coin debounced 3 cycles later -> single `reject` pulse, no second `x`; FSM returns to IDLE on schedule.
- Reset mid-operation: `rst` asserted the cycle `x = 01` is about to register -> `x`, `reject`, `busy` all 0 after that edge. The still-high sensor yields a fresh `x = 01` 6 edges after `rst` drops.
- Glitch rejection: 3-cycle high pulse on `coin50_raw` -> no `x`, no `reject`, `busy` stays 0.
